keypad_scanner: RTL and testbench

Scans a 4x4 hex matrix keypad, debounces it, and returns hex key codes. It is the input-side counterpart of the multiplexed 7-segment driver. The driver time-multiplexes outputs onto digit enables; this block time-multiplexes column drives and reads the row returns. The `digits` output is a 3-nibble history of accepted keys, formatted to wire straight into the display driver's 12-bit digit input.

---
 rtl/keypad_scanner.sv | 139 +++++++++++++
 tb/tb_keypad_scanner.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner with frame debounce.
// Emits key codes and a 3-key history for the display driver.
module keypad_scanner #(
  parameter int SCAN_DIV_BITS  = 17,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_down,
  output logic [11:0] digits
);

  localparam logic [3:0] STABLE_MAX = 4'(DEBOUNCE_SCANS - 1);

  // Result encoding: {key present, code}; all-zero means no key.
  localparam logic [4:0] RES_NONE = 5'b0_0000;

  logic [3:0]               rows_m;
  logic [3:0]               rows_s;
  logic [SCAN_DIV_BITS-1:0] presc;
  logic                     tick;
  logic [1:0]               col_idx;
  logic [1:0]               acc_cnt;
  logic [3:0]               acc_code;
  logic [4:0]               prev_res;
  logic [4:0]               acc_res;
  logic [3:0]               stable_cnt;

  logic [3:0] pressed;
  logic [1:0] base_cnt;
  logic [3:0] base_code;
  logic [2:0] hit_cnt;
  logic [2:0] sum_cnt;
  logic [1:0] new_cnt;
  logic [1:0] first_row;
  logic [3:0] new_code;
  logic [4:0] frame_res;
  logic       frame_end;
  logic       accept;

  assign tick      = &presc;
  assign frame_end = tick && (col_idx == 2'd3);
  assign cols      = ~(4'b0001 << col_idx);
  assign accept    = (stable_cnt == STABLE_MAX)
                  && (prev_res != acc_res);

  // Two-flop synchronizer for the asynchronous row returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_m <= 4'hF;
      rows_s <= 4'hF;
    end else begin
      rows_m <= rows;
      rows_s <= rows_m;
    end
  end

  // Free-running prescaler; all-ones is the scan tick.
  always_ff @(posedge clk) begin
    if (rst) presc <= '0;
    else     presc <= presc + SCAN_DIV_BITS'(1);
  end

  // Merge this column's sample into the running frame totals.
  always_comb begin
    pressed   = ~rows_s;
    base_cnt  = (col_idx == 2'd0) ? 2'd0 : acc_cnt;
    base_code = (col_idx == 2'd0) ? 4'd0 : acc_code;
    hit_cnt   = 3'(pressed[0]) + 3'(pressed[1])
              + 3'(pressed[2]) + 3'(pressed[3]);
    sum_cnt   = 3'(base_cnt) + hit_cnt;
    new_cnt   = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
    first_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (pressed[r]) first_row = 2'(r);
    end
    new_code  = base_code;
    if (base_cnt == 2'd0 && |pressed)
      new_code = {first_row, col_idx};
    frame_res = (new_cnt == 2'd1) ? {1'b1, new_code}
                                  : RES_NONE;
  end

  // Column stepping and frame accumulators, advanced on tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_idx  <= 2'd0;
      acc_cnt  <= 2'd0;
      acc_code <= 4'd0;
    end else if (tick) begin
      col_idx  <= col_idx + 2'd1;
      acc_cnt  <= new_cnt;
      acc_code <= new_code;
    end
  end

  // Count consecutive identical frame results.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_res   <= RES_NONE;
      stable_cnt <= 4'd0;
    end else if (frame_end) begin
      if (frame_res == prev_res) begin
        if (stable_cnt != STABLE_MAX)
          stable_cnt <= stable_cnt + 4'd1;
      end else begin
        stable_cnt <= 4'd0;
        prev_res   <= frame_res;
      end
    end
  end

  // Commit a stable result that differs from the accepted one.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_res   <= RES_NONE;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      digits    <= 12'h000;
    end else begin
      key_valid <= 1'b0;
      if (accept) begin
        acc_res  <= prev_res;
        key_down <= prev_res[4];
        if (prev_res[4]) begin
          key_valid <= 1'b1;
          key_code  <= prev_res[3:0];
          digits    <= {digits[7:0], prev_res[3:0]};
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner.
// Fast scan, short debounce, matrix model drives rows.
module tb_keypad_scanner;

  localparam int FRAME = 16;
  localparam int LAT   = 4 * FRAME + 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;
  logic [11:0] digits;
  logic [15:0] keys = '0;

  int n_chk = 0;
  int n_fail = 0;
  int pulse_cnt = 0;
  int dbl_cnt = 0;
  logic kv_d = 1'b0;
  int p0;
  bit seen;

  logic [3:0] col_pat [4];

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV_BITS (2),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rows     (rows),
    .cols     (cols),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down),
    .digits   (digits)
  );

  // Matrix model: a held key pulls its row low while its column is low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  // Pulse monitor.
  always @(negedge clk) begin
    if (key_valid) pulse_cnt <= pulse_cnt + 1;
    if (key_valid && kv_d) dbl_cnt <= dbl_cnt + 1;
    kv_d <= key_valid;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_pulse(output bit s);
    s = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      step(1);
      if (key_valid) begin
        s = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_release(input string tag);
    bit gone;
    gone = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      step(1);
      if (!key_down) begin
        gone = 1'b1;
        break;
      end
    end
    chk(tag, 32'(gone), 32'd1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cols"}, 32'(cols), 32'hE);
    chk({tag, "_code"}, 32'(key_code), 32'h0);
    chk({tag, "_valid"}, 32'(key_valid), 32'h0);
    chk({tag, "_down"}, 32'(key_down), 32'h0);
    chk({tag, "_digits"}, 32'(digits), 32'h000);
  endtask

  initial begin
    col_pat[0] = 4'b1110;
    col_pat[1] = 4'b1101;
    col_pat[2] = 4'b1011;
    col_pat[3] = 4'b0111;

    // 1: reset and idle column scan
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    chk_reset_state("rst");
    for (int k = 1; k < 64; k++) begin
      step(1);
      chk("idle_cols", 32'(cols), 32'(col_pat[(k/4)%4]));
    end
    chk("idle_pulses", 32'(pulse_cnt), 32'd0);
    chk("idle_down", 32'(key_down), 32'd0);
    chk("idle_digits", 32'(digits), 32'h000);

    // 2: press code 6, hold 10 frames, release
    p0 = pulse_cnt;
    keys = 16'h1 << 6;
    wait_pulse(seen);
    chk("t2_pulse", 32'(seen), 32'd1);
    chk("t2_code", 32'(key_code), 32'h6);
    chk("t2_digits", 32'(digits), 32'h006);
    step(1);
    chk("t2_down", 32'(key_down), 32'd1);
    step(6 * FRAME);
    chk("t2_once", 32'(pulse_cnt - p0), 32'd1);
    p0 = pulse_cnt;
    keys = '0;
    wait_release("t2_release");
    step(FRAME);
    chk("t2_rel_nopulse", 32'(pulse_cnt - p0), 32'd0);
    chk("t2_rel_code", 32'(key_code), 32'h6);
    chk("t2_rel_digits", 32'(digits), 32'h006);

    // 3: bounce code 6 every frame, then hold
    p0 = pulse_cnt;
    for (int f = 0; f < 5; f++) begin
      keys = (f % 2 == 0) ? (16'h1 << 6) : 16'h0;
      step(FRAME);
    end
    chk("t3_bounce", 32'(pulse_cnt - p0), 32'd0);
    chk("t3_bounce_down", 32'(key_down), 32'd0);
    keys = 16'h1 << 6;
    wait_pulse(seen);
    chk("t3_pulse", 32'(seen), 32'd1);
    chk("t3_code", 32'(key_code), 32'h6);
    step(4 * FRAME);
    chk("t3_once", 32'(pulse_cnt - p0), 32'd1);
    keys = '0;
    wait_release("t3_release");
    step(2 * FRAME);

    // 4: sequence 1, 2, 3, F
    p0 = pulse_cnt;
    keys = 16'h1 << 1;
    step(6 * FRAME);
    chk("t4_code1", 32'(key_code), 32'h1);
    keys = '0;
    step(6 * FRAME);
    keys = 16'h1 << 2;
    step(6 * FRAME);
    chk("t4_code2", 32'(key_code), 32'h2);
    keys = '0;
    step(6 * FRAME);
    keys = 16'h1 << 3;
    step(6 * FRAME);
    chk("t4_code3", 32'(key_code), 32'h3);
    keys = '0;
    step(6 * FRAME);
    keys = 16'h1 << 15;
    step(6 * FRAME);
    chk("t4_downF", 32'(key_down), 32'd1);
    keys = '0;
    step(6 * FRAME);
    chk("t4_pulses", 32'(pulse_cnt - p0), 32'd4);
    chk("t4_digits", 32'(digits), 32'h23F);
    chk("t4_code", 32'(key_code), 32'hF);
    chk("t4_up", 32'(key_down), 32'd0);

    // 5: two keys held is no key; releasing one yields the other
    p0 = pulse_cnt;
    keys = (16'h1 << 5) | (16'h1 << 10);
    step(8 * FRAME);
    chk("t5_multi", 32'(pulse_cnt - p0), 32'd0);
    chk("t5_multi_down", 32'(key_down), 32'd0);
    keys = 16'h1 << 5;
    wait_pulse(seen);
    chk("t5_pulse", 32'(seen), 32'd1);
    chk("t5_code", 32'(key_code), 32'h5);
    chk("t5_digits", 32'(digits), 32'h3F5);
    keys = '0;
    wait_release("t5_release");
    step(2 * FRAME);

    // 6: reset while holding code 9
    keys = 16'h1 << 9;
    wait_pulse(seen);
    chk("t6_pulse", 32'(seen), 32'd1);
    chk("t6_code", 32'(key_code), 32'h9);
    chk("t6_digits", 32'(digits), 32'hF59);
    step(2);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    chk_reset_state("t6_rst");
    wait_pulse(seen);
    chk("t6_repulse", 32'(seen), 32'd1);
    chk("t6_recode", 32'(key_code), 32'h9);
    chk("t6_redigits", 32'(digits), 32'h009);
    step(1);
    chk("t6_redown", 32'(key_down), 32'd1);
    keys = '0;
    step(6 * FRAME);

    chk("total_pulses", 32'(pulse_cnt), 32'd9);
    chk("no_double", 32'(dbl_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
